// File: rtl/collision_hit_arbiter_if.sv
// Bundles the per-pixel drawing requests coming in from the object drawers
// and the hit indications going out to the movers.
interface collision_hit_arbiter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   startOfFrame;
    logic                   playerDR;
    logic                   targetDR;
    logic                   borderDR;
    logic                   singleHit;
    logic                   borderHit;
    logic                   collisionActive;
    logic [COUNT_WIDTH-1:0] hitCount;

    modport master (
        output startOfFrame, playerDR, targetDR, borderDR,
        input  singleHit, borderHit, collisionActive, hitCount
    );

    modport slave (
        input  startOfFrame, playerDR, targetDR, borderDR,
        output singleHit, borderHit, collisionActive, hitCount
    );
endinterface

// File: rtl/collision_hit_arbiter.sv
// Turns per-pixel player/target and player/border overlaps into debounced
// one-clock hit pulses: one singleHit per contact (overlap threshold plus a
// frame-based cooldown) and one borderHit per frame.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_ARMED    | waiting for the frame's overlap count to reach MIN_OVERLAP
// ST_HIT      | hit fired this frame; leaves on the next start of frame
// ST_COOLDOWN | counting frame starts down before re-arming
module collision_hit_arbiter #(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    collision_hit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_HIT      = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [9:0] MIN_OVL = 10'(MIN_OVERLAP);
    localparam logic [7:0] CD_INIT = (COOLDOWN_FRAMES > 0) ? 8'(COOLDOWN_FRAMES - 1) : 8'd0;

    state_t                 state_q, state_d;
    logic [9:0]             ovl_cnt_q, ovl_cnt_d;
    logic [7:0]             cd_cnt_q, cd_cnt_d;
    logic                   border_seen_q, border_seen_d;
    logic                   single_hit_q, single_hit_d;
    logic                   border_hit_q, border_hit_d;
    logic                   active_q;
    logic [COUNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;

    logic sof;
    logic ovl;
    logic bov;

    assign sof = bus.startOfFrame;
    assign ovl = bus.playerDR & bus.targetDR;
    assign bov = bus.playerDR & bus.borderDR;

    // Per-frame overlap counter; the SOF pixel already belongs to the new frame.
    always_comb begin
        ovl_cnt_d = ovl_cnt_q;
        if (sof) begin
            ovl_cnt_d = {9'd0, ovl};
        end else if (ovl && (ovl_cnt_q != 10'h3FF)) begin
            ovl_cnt_d = ovl_cnt_q + 10'd1;
        end
    end

    // Hit FSM next state, cooldown counter, hit pulse and saturating hit count.
    // Armed compares the updated count, so a count already sitting at the
    // threshold when re-arming fires on the first armed cycle.
    always_comb begin
        state_d      = state_q;
        cd_cnt_d     = cd_cnt_q;
        single_hit_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        case (state_q)
            ST_ARMED: begin
                if (ovl_cnt_d == MIN_OVL) begin
                    state_d      = ST_HIT;
                    single_hit_d = 1'b1;
                    if (hit_cnt_q != {COUNT_WIDTH{1'b1}}) begin
                        hit_cnt_d = hit_cnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            ST_HIT: begin
                if (sof) begin
                    if (COOLDOWN_FRAMES > 0) begin
                        state_d  = ST_COOLDOWN;
                        cd_cnt_d = CD_INIT;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (sof) begin
                    if (cd_cnt_q == 8'd0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    // First player/border overlap of each frame, including the SOF pixel.
    always_comb begin
        border_hit_d  = 1'b0;
        border_seen_d = border_seen_q;
        if (sof) begin
            border_hit_d  = bov;
            border_seen_d = bov;
        end else if (bov && !border_seen_q) begin
            border_hit_d  = 1'b1;
            border_seen_d = 1'b1;
        end
    end

    // All state and outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_ARMED;
            ovl_cnt_q     <= 10'd0;
            cd_cnt_q      <= 8'd0;
            border_seen_q <= 1'b0;
            single_hit_q  <= 1'b0;
            border_hit_q  <= 1'b0;
            active_q      <= 1'b0;
            hit_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ovl_cnt_q     <= ovl_cnt_d;
            cd_cnt_q      <= cd_cnt_d;
            border_seen_q <= border_seen_d;
            single_hit_q  <= single_hit_d;
            border_hit_q  <= border_hit_d;
            active_q      <= ovl;
            hit_cnt_q     <= hit_cnt_d;
        end
    end

    assign bus.singleHit       = single_hit_q;
    assign bus.borderHit       = border_hit_q;
    assign bus.collisionActive = active_q;
    assign bus.hitCount        = hit_cnt_q;
endmodule

// File: tb/tb_collision_hit_arbiter.sv
// Directed bench for collision_hit_arbiter: a vector table for the basic
// hit/border/active behaviour, then hand-written multi-frame sequences.
module tb_collision_hit_arbiter;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    collision_hit_arbiter_if #(.COUNT_WIDTH(8)) bus0 ();
    collision_hit_arbiter_if #(.COUNT_WIDTH(8)) bus1 ();

    collision_hit_arbiter #(
        .MIN_OVERLAP(4), .COOLDOWN_FRAMES(8), .COUNT_WIDTH(8)
    ) u_dut0 (
        .clk(clk), .resetN(rst0), .bus(bus0)
    );

    collision_hit_arbiter #(
        .MIN_OVERLAP(1), .COOLDOWN_FRAMES(0), .COUNT_WIDTH(8)
    ) u_dut1 (
        .clk(clk), .resetN(rst1), .bus(bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       sof, p, t, b;
        logic       sh, bh, ca;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic sof, input logic p, input logic t, input logic b);
        bus0.startOfFrame = sof;
        bus0.playerDR     = p;
        bus0.targetDR     = t;
        bus0.borderDR     = b;
    endtask

    task automatic drive1(input logic sof, input logic p, input logic t, input logic b);
        bus1.startOfFrame = sof;
        bus1.playerDR     = p;
        bus1.targetDR     = t;
        bus1.borderDR     = b;
    endtask

    task automatic reset0();
        drive0(1'b0, 1'b0, 1'b0, 1'b0);
        rst0 = 1'b0;
        tick();
        tick();
        check("rst_single", 32'(bus0.singleHit), 0);
        check("rst_border", 32'(bus0.borderHit), 0);
        check("rst_active", 32'(bus0.collisionActive), 0);
        check("rst_count",  32'(bus0.hitCount), 0);
        rst0 = 1'b1;
    endtask

    initial begin
        int hits;
        int bhits;
        int exp_cnt;
        logic ovl;
        logic pb;
        logic exp_sh;

        // sof p t b | single border active | hitCount
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        rst1 = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        // Vector table: threshold hit, held overlap, border per frame.
        reset0();
        for (int i = 0; i < 12; i++) begin
            drive0(vecs[i].sof, vecs[i].p, vecs[i].t, vecs[i].b);
            tick();
            check($sformatf("vec%0d_single", i), 32'(bus0.singleHit), 32'(vecs[i].sh));
            check($sformatf("vec%0d_border", i), 32'(bus0.borderHit), 32'(vecs[i].bh));
            check($sformatf("vec%0d_active", i), 32'(bus0.collisionActive), 32'(vecs[i].ca));
            check($sformatf("vec%0d_count", i),  32'(bus0.hitCount), 32'(vecs[i].cnt));
        end

        // Continuous overlap, 20 frames of 100 pixels: hits in frames 0, 9, 18.
        reset0();
        hits = 0;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 100; i++) begin
                drive0(i == 0, 1'b1, 1'b1, 1'b0);
                tick();
                exp_sh = ((f == 0) || (f == 9) || (f == 18)) && (i == 3);
                if (bus0.singleHit === 1'b1) hits++;
                check("cont_single", 32'(bus0.singleHit), 32'(exp_sh));
            end
        end
        check("cont_hits", 32'(hits), 3);
        check("cont_count", 32'(bus0.hitCount), 3);

        // Three overlap pixels per frame never reach the threshold.
        reset0();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 10; i++) begin
                ovl = (i >= 2) && (i <= 4);
                drive0(i == 0, 1'b1, ovl, 1'b0);
                tick();
                check("sub_single", 32'(bus0.singleHit), 0);
                check("sub_active", 32'(bus0.collisionActive), 32'(ovl));
            end
        end
        check("sub_count", 32'(bus0.hitCount), 0);

        // Player/border overlap including the SOF pixel: one borderHit per frame.
        reset0();
        bhits = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 60; i++) begin
                pb = (i < 50);
                drive0(i == 0, pb, 1'b0, pb);
                tick();
                if (bus0.borderHit === 1'b1) bhits++;
                check("brd_border", 32'(bus0.borderHit), 32'(i == 0));
                check("brd_single", 32'(bus0.singleHit), 0);
            end
        end
        check("brd_hits", 32'(bhits), 3);

        // Two hits, then reset while cooling down (cdCnt at 5).
        reset0();
        for (int f = 0; f < 13; f++) begin
            for (int i = 0; i < 6; i++) begin
                ovl = ((f == 0) || (f == 9)) && (i >= 1) && (i <= 4);
                drive0(i == 0, ovl, ovl, 1'b0);
                tick();
                check("cd_single", 32'(bus0.singleHit), 32'(ovl && (i == 4)));
            end
        end
        drive0(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("cd_pre_active", 32'(bus0.collisionActive), 1);
        check("cd_pre_count",  32'(bus0.hitCount), 2);
        check("cd_pre_single", 32'(bus0.singleHit), 0);
        rst0 = 1'b0;
        #2;
        check("cd_rst_active", 32'(bus0.collisionActive), 0);
        check("cd_rst_count",  32'(bus0.hitCount), 0);
        check("cd_rst_single", 32'(bus0.singleHit), 0);
        drive0(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst0 = 1'b1;
        tick();
        check("cd_rel_single", 32'(bus0.singleHit), 0);
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            check("cd_rearm_single", 32'(bus0.singleHit), 32'(i == 3));
        end
        check("cd_rearm_count", 32'(bus0.hitCount), 1);
        drive0(1'b0, 1'b0, 1'b0, 1'b0);

        // MIN_OVERLAP=1, no cooldown, overlap only on SOF: saturating count.
        check("sat_rst_count", 32'(bus1.hitCount), 0);
        check("sat_rst_single", 32'(bus1.singleHit), 0);
        rst1 = 1'b1;
        hits = 0;
        exp_cnt = 0;
        for (int f = 0; f < 260; f++) begin
            for (int i = 0; i < 3; i++) begin
                drive1(i == 0, i == 0, i == 0, 1'b0);
                tick();
                exp_sh = (f == 0) ? (i == 0) : (i == 1);
                if (exp_sh && (exp_cnt < 255)) exp_cnt++;
                if (bus1.singleHit === 1'b1) hits++;
                check("sat_single", 32'(bus1.singleHit), 32'(exp_sh));
                check("sat_count",  32'(bus1.hitCount), 32'(exp_cnt));
            end
        end
        check("sat_hits", 32'(hits), 260);
        check("sat_final", 32'(bus1.hitCount), 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
